// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of uart_tx_fifo: the byte producer's strobe and data plus the
// FIFO status returned to it.
//   wr_data  : byte to queue
//   wr_en    : write strobe, one byte per cycle while high
//   full     : FIFO holds DEPTH entries
//   empty    : FIFO holds 0 entries
//   count    : current occupancy, $clog2(DEPTH)+1 bits
//   overflow : sticky, a write was attempted while full
// master = byte producer, slave = uart_tx_fifo.
interface uart_tx_fifo_if #(
  parameter int unsigned DEPTH = 16
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [7:0]      wr_data;
  logic            wr_en;
  logic            full;
  logic            empty;
  logic [CntW-1:0] count;
  logic            overflow;

  modport master (
    output wr_data,
    output wr_en,
    input  full,
    input  empty,
    input  count,
    input  overflow
  );

  modport slave (
    input  wr_data,
    input  wr_en,
    output full,
    output empty,
    output count,
    output overflow
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter. Bytes written through wr_if are queued in a
// DEPTH-entry FIFO and sent on TX as frames of start, 8 data bits LSB first,
// optional parity and one stop bit. A new frame is popped on the last stop
// cycle when data is waiting, so bursts go out with no idle gap.
// Ports:
//   CLK   : system clock, rising edge
//   RST_N : asynchronous active-low reset
//   wr_if : write-side bus (slave modport), see uart_tx_fifo_if
//   TX    : registered serial output, idle high
//   busy  : serialiser not idle
module uart_tx_fifo #(
  parameter int unsigned CLK_MHZ = 12,
  parameter int unsigned BAUD    = 9600,
  parameter logic [1:0]  PARITY  = 2'b00,
  parameter int unsigned DEPTH   = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  uart_tx_fifo_if.slave wr_if,
  output logic          TX,
  output logic          busy
);

  localparam int unsigned Div       = (CLK_MHZ * 1_000_000) / BAUD;
  localparam int unsigned TimerW    = $clog2(Div);
  localparam int unsigned PtrW      = $clog2(DEPTH);
  localparam int unsigned CntW      = PtrW + 1;
  localparam bit          HasParity = (PARITY == 2'b01) || (PARITY == 2'b10);
  localparam logic [TimerW-1:0] Reload = TimerW'(Div - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  // FIFO storage and pointers
  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, empty;
  logic            wr_accept;
  logic            pop;

  // Serialiser
  state_e            state_q, state_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic [7:0]        head;
  logic              head_par;
  logic              timer_done;

  // Status is derived from the registered count, so a pop on the same edge
  // cannot make room for a write while full.
  assign full      = (count_q == CntW'(DEPTH));
  assign empty     = (count_q == '0);
  assign wr_accept = wr_if.wr_en && !full;

  assign head     = mem_q[rd_ptr_q];
  // Odd mode inverts the even-parity XOR.
  assign head_par = (PARITY == 2'b01) ? ~(^head) : (^head);

  assign timer_done = (timer_q == '0);

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (wr_if.wr_en & full);

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q] <= wr_if.wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Serialiser next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    pop       = 1'b0;

    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = head;
          par_d     = head_par;
          bit_cnt_d = 3'd0;
          timer_d   = Reload;
          state_d   = StStart;
        end
      end

      StStart: begin
        if (timer_done) begin
          timer_d = Reload;
          state_d = StData;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      StData: begin
        if (timer_done) begin
          timer_d = Reload;
          if (bit_cnt_q == 3'd7) begin
            state_d = HasParity ? StParity : StStop;
          end else begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      StParity: begin
        if (timer_done) begin
          timer_d = Reload;
          state_d = StStop;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      StStop: begin
        if (timer_done) begin
          if (!empty) begin
            // Chain straight into the next start bit, no idle cycle.
            pop       = 1'b1;
            shift_d   = head;
            par_d     = head_par;
            bit_cnt_d = 3'd0;
            timer_d   = Reload;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // TX is registered from the next state, so the line changes on the same edge
  // as the state and has no combinational path from wr_if.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
      StParity: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
    end
  end

  assign TX             = tx_q;
  assign busy           = (state_q != StIdle);
  assign wr_if.full     = full;
  assign wr_if.empty    = empty;
  assign wr_if.count    = count_q;
  assign wr_if.overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Shared write stimulus, steered to the instance selected by cur.
  int         cur;
  logic       wr_en_b;
  logic [7:0] wr_data_b;

  uart_tx_fifo_if #(.DEPTH(16)) if_np ();
  uart_tx_fifo_if #(.DEPTH(16)) if_ev ();
  uart_tx_fifo_if #(.DEPTH(16)) if_od ();
  uart_tx_fifo_if #(.DEPTH(16)) if_df ();

  assign if_np.wr_en = wr_en_b && (cur == 0);
  assign if_ev.wr_en = wr_en_b && (cur == 1);
  assign if_od.wr_en = wr_en_b && (cur == 2);
  assign if_df.wr_en = wr_en_b && (cur == 3);
  assign if_np.wr_data = wr_data_b;
  assign if_ev.wr_data = wr_data_b;
  assign if_od.wr_data = wr_data_b;
  assign if_df.wr_data = wr_data_b;

  logic tx_np, tx_ev, tx_od, tx_df;
  logic busy_np, busy_ev, busy_od, busy_df;

  uart_tx_fifo #(.CLK_MHZ(1), .BAUD(250000), .PARITY(2'b00), .DEPTH(16)) u_np (
    .CLK(clk), .RST_N(rst_n), .wr_if(if_np), .TX(tx_np), .busy(busy_np)
  );
  uart_tx_fifo #(.CLK_MHZ(1), .BAUD(250000), .PARITY(2'b10), .DEPTH(16)) u_ev (
    .CLK(clk), .RST_N(rst_n), .wr_if(if_ev), .TX(tx_ev), .busy(busy_ev)
  );
  uart_tx_fifo #(.CLK_MHZ(1), .BAUD(250000), .PARITY(2'b01), .DEPTH(16)) u_od (
    .CLK(clk), .RST_N(rst_n), .wr_if(if_od), .TX(tx_od), .busy(busy_od)
  );
  uart_tx_fifo u_df (
    .CLK(clk), .RST_N(rst_n), .wr_if(if_df), .TX(tx_df), .busy(busy_df)
  );

  // Outputs of the selected instance.
  logic       tx_m, busy_m, full_m, empty_m, ovf_m;
  logic [4:0] cnt_m;
  always_comb begin
    tx_m = 1'b1; busy_m = 1'b0; full_m = 1'b0; empty_m = 1'b1; ovf_m = 1'b0; cnt_m = '0;
    case (cur)
      0: begin
        tx_m = tx_np; busy_m = busy_np; full_m = if_np.full; empty_m = if_np.empty;
        ovf_m = if_np.overflow; cnt_m = if_np.count;
      end
      1: begin
        tx_m = tx_ev; busy_m = busy_ev; full_m = if_ev.full; empty_m = if_ev.empty;
        ovf_m = if_ev.overflow; cnt_m = if_ev.count;
      end
      2: begin
        tx_m = tx_od; busy_m = busy_od; full_m = if_od.full; empty_m = if_od.empty;
        ovf_m = if_od.overflow; cnt_m = if_od.count;
      end
      default: begin
        tx_m = tx_df; busy_m = busy_df; full_m = if_df.full; empty_m = if_df.empty;
        ovf_m = if_df.overflow; cnt_m = if_df.count;
      end
    endcase
  end

  typedef struct {
    int         sel;
    logic [7:0] data;
    int         nbits;
    logic [10:0] exp;   // bit i = i-th bit on the line (start first)
    string      name;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(input int sel, input logic [7:0] data, input int nbits,
                              input logic [10:0] exp, input string name);
    vec_t v;
    v.sel = sel; v.data = data; v.nbits = nbits; v.exp = exp; v.name = name;
    return v;
  endfunction

  // Plain 8N1 frame in line order.
  function automatic logic [10:0] frm(input logic [7:0] d);
    return {1'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Entered just after the edge that starts the start bit; returns just after
  // the edge that starts the last cycle of the stop bit.
  task automatic check_frame(input logic [10:0] exp, input int nbits, input int div,
                             input string name);
    for (int i = 0; i < nbits; i++) begin
      int bad;
      bad = 0;
      for (int c = 0; c < div; c++) begin
        if (i != 0 || c != 0) begin
          @(posedge clk); #1;
        end
        if (tx_m !== exp[i]) bad++;
      end
      chk($sformatf("%s bit%0d bad_cycles", name, i), bad, 0);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int div;
    div = (v.sel == 3) ? 1250 : 4;
    cur = v.sel;
    wr_data_b = v.data;
    wr_en_b = 1'b1;
    @(posedge clk); #1;
    wr_en_b = 1'b0;
    chk({v.name, " count after write"}, cnt_m, 1);
    chk({v.name, " tx idle after write"}, tx_m, 1);
    @(posedge clk); #1;
    check_frame(v.exp, v.nbits, div, v.name);
    @(posedge clk); #1;
    chk({v.name, " busy,tx,empty at end"}, {busy_m, tx_m, empty_m}, 3'b011);
  endtask

  initial begin
    vecs[0] = mk(0, 8'h55, 10, 11'h2AA, "np_55");
    vecs[1] = mk(0, 8'hA3, 10, 11'h346, "np_a3");
    vecs[2] = mk(0, 8'h00, 10, 11'h200, "np_00");
    vecs[3] = mk(0, 8'hFF, 10, 11'h3FE, "np_ff");
    vecs[4] = mk(1, 8'h07, 11, 11'h60E, "even_07");
    vecs[5] = mk(2, 8'h07, 11, 11'h40E, "odd_07");
    vecs[6] = mk(1, 8'h80, 11, 11'h700, "even_80");
    vecs[7] = mk(2, 8'h00, 11, 11'h600, "odd_00");
    vecs[8] = mk(1, 8'h00, 11, 11'h400, "even_00");
    vecs[9] = mk(3, 8'hA3, 10, 11'h346, "default_a3");

    cur = 0; wr_en_b = 1'b0; wr_data_b = 8'h00; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    for (int s = 0; s < 4; s++) begin
      cur = s;
      #1;
      chk($sformatf("reset inst%0d tx,busy,full,empty,ovf,count", s),
          {tx_m, busy_m, full_m, empty_m, ovf_m, cnt_m}, {5'b10010, 5'd0});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-frame vectors
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Burst of 20 writes: 17 accepted, then overflow; 17 frames with no gap.
    cur = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) begin
          wr_data_b = 8'h30 + 8'(k);
          wr_en_b = 1'b1;
          @(posedge clk); #1;
          if (k == 15) chk("burst 16th write full,ovf,count", {full_m, ovf_m, cnt_m},
                           {2'b00, 5'd15});
          if (k == 16) chk("burst 17th write full,ovf,count", {full_m, ovf_m, cnt_m},
                           {2'b10, 5'd16});
          if (k == 17) chk("burst rejected write full,ovf,count", {full_m, ovf_m, cnt_m},
                           {2'b11, 5'd16});
        end
        wr_en_b = 1'b0;
      end
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int j = 0; j < 17; j++) begin
          check_frame(frm(8'h30 + 8'(j)), 10, 4, $sformatf("burst frame%0d", j));
          @(posedge clk); #1;
        end
        chk("burst end busy,tx,empty", {busy_m, tx_m, empty_m}, 3'b011);
      end
    join

    // Write on the STOP-end pop edge while count=1.
    cur = 0;
    wr_data_b = 8'hC5; wr_en_b = 1'b1;
    @(posedge clk); #1;
    wr_data_b = 8'h3A;
    @(posedge clk); #1;
    wr_en_b = 1'b0;
    chk("idle pop+write count", cnt_m, 1);
    check_frame(frm(8'hC5), 10, 4, "simul frameA");
    wr_data_b = 8'h96; wr_en_b = 1'b1;
    @(posedge clk); #1;
    wr_en_b = 1'b0;
    chk("stop pop+write count", cnt_m, 1);
    check_frame(frm(8'h3A), 10, 4, "simul frameB");
    @(posedge clk); #1;
    check_frame(frm(8'h96), 10, 4, "simul frameC");
    @(posedge clk); #1;
    chk("simul end busy,tx,empty", {busy_m, tx_m, empty_m}, 3'b011);

    // Reset during data bit 3 with 3 bytes queued.
    cur = 0;
    for (int k = 0; k < 4; k++) begin
      wr_data_b = 8'h11 * 8'(k + 1);
      wr_en_b = 1'b1;
      @(posedge clk); #1;
    end
    wr_en_b = 1'b0;
    chk("pre-reset count", cnt_m, 3);
    repeat (15) @(posedge clk);
    #1;
    chk("pre-reset tx (bit3 of 0x11)", {busy_m, tx_m}, 2'b10);
    rst_n = 1'b0;
    #1;
    chk("async reset tx,busy,full,empty,ovf,count",
        {tx_m, busy_m, full_m, empty_m, ovf_m, cnt_m}, {5'b10010, 5'd0});
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int bad;
      bad = 0;
      for (int c = 0; c < 60; c++) begin
        @(posedge clk); #1;
        if (tx_m !== 1'b1 || busy_m !== 1'b0 || cnt_m !== 5'd0) bad++;
      end
      chk("post-reset quiet bad_cycles", bad, 0);
    end
    run_vec(mk(0, 8'h5A, 10, 11'h2B4, "post_reset_5a"));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
